stepper_move_ctrl: RTL and testbench
====================================

Name: stepper_move_ctrl

Overview:
Move controller that sequences the 4-phase stepper motor output from buffered move commands. Each command carries a step count, direction and step-rate divisor. The block generates timed steps, advances the phase pattern, and tracks absolute position. After a move it holds the coil energized for a programmable delay, then de-energizes. It sits between the system command logic and the motor pins, replacing free-running phase counting with commanded motion.

Parameters:
STEP_W, 16, width of step count in a command
DIV_W, 16, width of step-rate divisor (clk cycles per step)
POS_W, 24, width of absolute position counter
OFF_DLY, 50000, clk cycles of energized hold after a move before de-energizing

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted this cycle
cmd_steps  in  STEP_W  number of steps to take
cmd_dir  in  1  1 = forward (phase index +1), 0 = reverse (phase index -1)
cmd_div  in  DIV_W  cycles per step; 0 treated as 1
abort  in  1  terminate current move
motorpin  out  4  coil drive pattern
step_pulse  out  1  one-cycle pulse per step taken
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at move completion or abort
position  out  POS_W  absolute position, modulo 2^POS_W

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset values: state OFF, motorpin 4'b0000, phase index 0, position 0, step_pulse 0, busy 0, done 0. cmd_ready follows the state rule below.
- Phase patterns: index 0 = 1000, 1 = 0100, 2 = 0010, 3 = 0001. The index wraps modulo 4 in both directions.
- All outputs are registered except cmd_ready.
- Command handshake:
  - A command is accepted on a clk edge where cmd_valid && cmd_ready.
  - cmd_ready = (state == OFF || state == HOLD) && !abort.
  - Fields are latched on acceptance. D = max(cmd_div, 1).
- States:
  - OFF:
    - motorpin = 0000.
    - Accept with steps == 0: done pulses in the next cycle; stay in OFF; motorpin stays 0000.
    - Accept with steps > 0: go to RUN. motorpin = pattern[index] from the next cycle. The current phase is energized before the first step.
  - RUN:
    - busy = 1; cmd_ready = 0.
    - The rate counter is loaded so that steps occur in cycles A+D, A+2D, …, A+N·D, where A is the acceptance edge.
    - On each step, all in the same cycle: step_pulse = 1, index ± 1, motorpin updated to the new pattern, position ± 1 (wraps), remaining − 1.
    - On the final step, done = 1 in the same cycle and the state goes to HOLD.
  - HOLD:
    - motorpin holds pattern[index]. The hold counter is cleared on entry.
    - After OFF_DLY cycles with no accepted command, go to OFF and motorpin = 0000.
    - Accept with steps > 0: go directly to RUN with no de-energize gap. The hold counter is cleared.
    - Accept with steps == 0: done pulses next cycle; remain in HOLD; the hold counter restarts.
- abort:
  - In RUN: takes effect at the next edge. Go to HOLD, clear remaining, no further step, done pulses in that cycle.
  - Abort beats a step due in the same cycle: no step_pulse, position unchanged.
  - In OFF or HOLD: no state effect, but it blocks acceptance via cmd_ready.
- Position wraps silently: 0 − 1 = 2^POS_W − 1.
- Reset asserted mid-move: all registers return to reset values at that edge. The move is lost and no done pulse is generated.
- cmd_valid while in RUN is ignored; commands are not queued.

Test Plan:
1. Forward move: after reset, command steps=4, dir=1, div=3 accepted at cycle 0.
   - Required: motorpin 1000 from cycle 1.
   - step_pulse at cycles 3, 6, 9, 12; motorpin 0100, 0010, 0001, 1000.
   - position = 4; done at cycle 12.
   - busy high cycles 1–12; cmd_ready low in the same span.
2. Reverse with wrap: from reset, steps=2, dir=0, div=0.
   - Required: steps occur every cycle (div 0 treated as 1).
   - motorpin 0001 then 0010.
   - position = 0xFFFFFE.
3. Zero-step command in OFF:
   - Required: done pulses one cycle after acceptance.
   - No step_pulse; motorpin stays 0000; state OFF; busy never high.
4. Abort: steps=10, div=4; abort asserted after the 2nd step_pulse, coincident with the 3rd step's due cycle.
   - Required: no 3rd step; position = 2; done pulse.
   - HOLD entered: motorpin 0010 held; cmd_ready high once abort is low.
5. HOLD behaviour with OFF_DLY = 8:
   - Idle after a move: motorpin goes to 0000 exactly 8 cycles after HOLD entry.
   - Repeat, with a new command (steps=1) accepted 5 cycles into HOLD: RUN entered directly, motorpin never 0000.
6. Reset mid-run (steps=100, after 7 steps):
   - Required: next cycle motorpin 0000, position 0, busy 0, done 0, cmd_ready 1, state OFF.

Source files
------------

// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: runs buffered move commands on a 4-phase stepper.
// Each command gives a step count, a direction and a step-rate divisor.
// The block produces timed steps, drives the coil phase pattern and keeps
// an absolute position. When a move ends, the coil stays energized for
// OFF_DLY cycles. After that delay the coil is released.
module stepper_move_ctrl #(
  parameter int STEP_W  = 16,
  parameter int DIV_W   = 16,
  parameter int POS_W   = 24,
  parameter int OFF_DLY = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic [DIV_W-1:0]  cmd_div,
  input  logic              abort,
  output logic [3:0]        motorpin,
  output logic              step_pulse,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position,
  output logic [1:0]        dbg_state
);

  localparam int HOLD_W = $clog2(OFF_DLY + 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              dir_q, dir_d;
  logic [DIV_W-1:0]  rate_q, rate_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        motorpin_q, motorpin_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic [DIV_W-1:0]  div_eff;

  // Phase index i drives exactly one coil. Index 0 gives 1000 and
  // index 3 gives 0001.
  function automatic logic [3:0] phase_pat(input logic [1:0] i);
    return 4'b1000 >> i;
  endfunction

  // Command handshake: a command transfers on a rising edge when both
  // cmd_valid and cmd_ready are high. All fields are captured at that
  // edge. cmd_ready is high only in OFF or HOLD and only while abort is
  // low. It does not depend on cmd_valid.
  assign cmd_ready = ((state_q == S_OFF) || (state_q == S_HOLD)) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign div_eff   = (cmd_div == '0) ? DIV_W'(1) : cmd_div;

  // Next-state logic for the FSM, the counters and the registered outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    rem_d   = rem_q;
    div_d   = div_q;
    dir_d   = dir_q;
    rate_d  = rate_q;
    hold_d  = hold_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_OFF: begin
        if (accept) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = cmd_steps;
            dir_d   = cmd_dir;
            div_d   = div_eff;
            rate_d  = div_eff;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          // When abort and a due step fall in the same cycle, abort wins.
          state_d = S_HOLD;
          rem_d   = '0;
          done_d  = 1'b1;
          hold_d  = '0;
        end else if (rate_q == DIV_W'(1)) begin
          step_d = 1'b1;
          idx_d  = dir_q ? (idx_q + 2'd1) : (idx_q - 2'd1);
          pos_d  = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
          rem_d  = rem_q - STEP_W'(1);
          rate_d = div_q;
          if (rem_q == STEP_W'(1)) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
            hold_d  = '0;
          end
        end else begin
          rate_d = rate_q - DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (accept) begin
          hold_d = '0;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = cmd_steps;
            dir_d   = cmd_dir;
            div_d   = div_eff;
            rate_d  = div_eff;
          end
        end else if (hold_q == HOLD_W'(OFF_DLY - 1)) begin
          state_d = S_OFF;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    motorpin_d = (state_d == S_OFF) ? 4'b0000 : phase_pat(idx_d);
    busy_d     = (state_d == S_RUN);
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_OFF;
      idx_q      <= 2'd0;
      pos_q      <= '0;
      rem_q      <= '0;
      div_q      <= DIV_W'(1);
      dir_q      <= 1'b0;
      rate_q     <= DIV_W'(1);
      hold_q     <= '0;
      motorpin_q <= 4'b0000;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      dir_q      <= dir_d;
      rate_q     <= rate_d;
      hold_q     <= hold_d;
      motorpin_q <= motorpin_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign motorpin   = motorpin_q;
  assign step_pulse = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign position   = pos_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl. Each test pushes its expected step and done
// events into a queue. Every event word holds the step flag, the done
// flag, motorpin, position and the cycle offset from the acceptance edge.
// A monitor pops and compares an entry each time step_pulse or done is
// high.
module tb_stepper_move_ctrl;

  localparam int STEP_W  = 16;
  localparam int DIV_W   = 16;
  localparam int POS_W   = 24;
  localparam int OFF_DLY = 8;
  localparam int EW      = 2 + 4 + POS_W + 16;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic [DIV_W-1:0]  cmd_div;
  logic              abort;
  logic [3:0]        motorpin;
  logic              step_pulse;
  logic              busy;
  logic              done;
  logic [POS_W-1:0]  position;
  logic [1:0]        dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  stepper_move_ctrl #(
    .STEP_W (STEP_W),
    .DIV_W  (DIV_W),
    .POS_W  (POS_W),
    .OFF_DLY(OFF_DLY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .cmd_div   (cmd_div),
    .abort     (abort),
    .motorpin  (motorpin),
    .step_pulse(step_pulse),
    .busy      (busy),
    .done      (done),
    .position  (position),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic st, input logic dn, input logic [3:0] mp,
                         input logic [POS_W-1:0] pos, input int rel);
    exp_q.push_back({st, dn, mp, pos, 16'(rel)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Call this at a falling edge. The command transfers on the next rising
  // edge, and the task returns at the falling edge that follows it.
  task automatic send_cmd(input logic [STEP_W-1:0] steps, input logic dir,
                          input logic [DIV_W-1:0] div);
    acc_cyc   = cyc + 1;
    cmd_steps = steps;
    cmd_dir   = dir;
    cmd_div   = div;
    cmd_valid = 1'b1;
    #1;
    check("accept_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d events still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (step_pulse === 1'b1 || done === 1'b1) begin
        obs = {step_pulse, done, motorpin, position, 16'(cyc - acc_cyc)};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got event 0x%0h, expected no event", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            n_fail++;
            $display("FAIL sb_event: got 0x%0h, expected 0x%0h", obs, exp);
          end
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int bad;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir   = 1'b0;
    cmd_div   = '0;
    abort     = 1'b0;

    // Check the state right after reset.
    do_reset();
    check("rst_motorpin", 32'(motorpin), 32'h0);
    check("rst_position", 32'(position), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_step", 32'(step_pulse), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    check("rst_state", 32'(dbg_state), 32'(ST_OFF));

    // 1: forward move, 4 steps, div 3.
    push_ev(1'b1, 1'b0, 4'b0100, 24'd1, 3);
    push_ev(1'b1, 1'b0, 4'b0010, 24'd2, 6);
    push_ev(1'b1, 1'b0, 4'b0001, 24'd3, 9);
    push_ev(1'b1, 1'b1, 4'b1000, 24'd4, 12);
    send_cmd(16'd4, 1'b1, 16'd3);
    check("t1_energize", 32'(motorpin), 32'h8);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy !== 1'b1 || cmd_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    check("t1_busy_span", 32'(bad), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_state_hold", 32'(dbg_state), 32'(ST_HOLD));
    check("t1_position", 32'(position), 32'd4);
    drain("t1");

    // 2: reverse move with div 0. The position wraps below zero.
    do_reset();
    push_ev(1'b1, 1'b0, 4'b0001, 24'hFFFFFF, 1);
    push_ev(1'b1, 1'b1, 4'b0010, 24'hFFFFFE, 2);
    send_cmd(16'd2, 1'b0, 16'd0);
    wait_neg(2);
    check("t2_position", 32'(position), 32'hFFFFFE);
    check("t2_motorpin", 32'(motorpin), 32'h2);
    drain("t2");

    // 3: zero-step command while in OFF.
    do_reset();
    push_ev(1'b0, 1'b1, 4'b0000, 24'd0, 0);
    send_cmd(16'd0, 1'b1, 16'd5);
    check("t3_state", 32'(dbg_state), 32'(ST_OFF));
    check("t3_motorpin", 32'(motorpin), 32'h0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy !== 1'b0 || motorpin !== 4'b0000) bad++;
      @(negedge clk);
    end
    check("t3_idle", 32'(bad), 32'd0);
    drain("t3");

    // 4: abort arrives in the same cycle that the 3rd step is due.
    do_reset();
    push_ev(1'b1, 1'b0, 4'b0100, 24'd1, 4);
    push_ev(1'b1, 1'b0, 4'b0010, 24'd2, 8);
    push_ev(1'b0, 1'b1, 4'b0010, 24'd2, 12);
    send_cmd(16'd10, 1'b1, 16'd4);
    wait_neg(11);
    abort = 1'b1;
    @(negedge clk);
    check("t4_ready_blocked", 32'(cmd_ready), 32'd0);
    check("t4_state_hold", 32'(dbg_state), 32'(ST_HOLD));
    check("t4_no_step", 32'(step_pulse), 32'd0);
    abort = 1'b0;
    #1;
    check("t4_ready", 32'(cmd_ready), 32'd1);
    wait_neg(4);
    check("t4_position", 32'(position), 32'd2);
    check("t4_motorpin", 32'(motorpin), 32'h2);
    drain("t4");

    // 5a: HOLD times out exactly OFF_DLY cycles after it is entered.
    do_reset();
    push_ev(1'b1, 1'b1, 4'b0100, 24'd1, 1);
    send_cmd(16'd1, 1'b1, 16'd1);
    wait_neg(8);
    check("t5_hold_before", 32'(motorpin), 32'h4);
    check("t5_state_before", 32'(dbg_state), 32'(ST_HOLD));
    @(negedge clk);
    check("t5_off_after", 32'(motorpin), 32'h0);
    check("t5_state_after", 32'(dbg_state), 32'(ST_OFF));
    drain("t5a");

    // 5b: a new command accepted 5 cycles into HOLD goes straight to RUN.
    push_ev(1'b1, 1'b1, 4'b0010, 24'd2, 1);
    send_cmd(16'd1, 1'b1, 16'd1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (motorpin === 4'b0000) bad++;
      @(negedge clk);
    end
    push_ev(1'b1, 1'b1, 4'b0001, 24'd3, 2);
    send_cmd(16'd1, 1'b1, 16'd2);
    check("t5_direct_run", 32'(dbg_state), 32'(ST_RUN));
    for (int k = 0; k < 2; k++) begin
      if (motorpin === 4'b0000) bad++;
      @(negedge clk);
    end
    check("t5_never_off", 32'(bad), 32'd0);
    check("t5_rehold", 32'(dbg_state), 32'(ST_HOLD));
    check("t5_motorpin", 32'(motorpin), 32'h1);
    drain("t5b");

    // 6: reset asserted in the middle of a move.
    do_reset();
    push_ev(1'b1, 1'b0, 4'b0100, 24'd1, 1);
    push_ev(1'b1, 1'b0, 4'b0010, 24'd2, 2);
    push_ev(1'b1, 1'b0, 4'b0001, 24'd3, 3);
    push_ev(1'b1, 1'b0, 4'b1000, 24'd4, 4);
    push_ev(1'b1, 1'b0, 4'b0100, 24'd5, 5);
    push_ev(1'b1, 1'b0, 4'b0010, 24'd6, 6);
    push_ev(1'b1, 1'b0, 4'b0001, 24'd7, 7);
    send_cmd(16'd100, 1'b1, 16'd1);
    wait_neg(7);
    check("t6_pos_before", 32'(position), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    check("t6_motorpin", 32'(motorpin), 32'h0);
    check("t6_position", 32'(position), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_done", 32'(done), 32'h0);
    check("t6_ready", 32'(cmd_ready), 32'h1);
    check("t6_state", 32'(dbg_state), 32'(ST_OFF));
    reset = 1'b0;
    wait_neg(3);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
